hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//   Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting between the
//   IF/ID, ID/EX and PC control points. Detects load-use hazards and stalls for a configurable
//   number of cycles (LOAD_LAT). Flushes wrong-path instructions on a taken branch/jump
//   resolved in EX. Freezes the front-end while a multi-cycle EX unit is busy. Keeps a
//   saturating stall-cycle performance counter.
// PARAMETERS
//   REG_ADDR_WIDTH  5   register index width
//   LOAD_LAT        1   load-use stall cycles, legal range 1..(2**CNT_WIDTH-1)
//   CNT_WIDTH       3   width of the internal stall countdown counter
//   PERF_WIDTH      32  width of the stall-cycle performance counter
// PORTS
//   clk              in   1               core clock, all state on rising edge
//   rst_n            in   1               asynchronous active-low reset
//   IF_ID_rs1        in   REG_ADDR_WIDTH  IF/ID.RegisterRs1
//   IF_ID_rs2        in   REG_ADDR_WIDTH  IF/ID.RegisterRs2
//   IF_ID_rs1_used   in   1               decoded instruction reads rs1
//   IF_ID_rs2_used   in   1               decoded instruction reads rs2
//   ID_EX_rd         in   REG_ADDR_WIDTH  ID/EX.RegisterRd
//   ID_EX_mem_rd_en  in   1               ID/EX holds a load
//   ID_EX_reg_wr_en  in   1               ID/EX writes rd
//   EX_br_taken      in   1               branch/jump in EX resolved taken (PC redirect this cycle)
//   ex_busy          in   1               multi-cycle EX unit occupied; EX result not ready
//   pc_write         out  1               1 = PC register loads next value
//   IF_ID_write      out  1               1 = IF/ID register loads
//   ID_EX_write      out  1               1 = ID/EX register loads
//   IF_ID_flush      out  1               1 = IF/ID loads a NOP
//   ctrl_sel         out  1               1 = zero control into ID/EX (bubble)
//   stall            out  1               1 = a load-use stall or EX freeze is active this cycle
//   stall_cycles     out  PERF_WIDTH      saturating count of cycles with stall=1
// BEHAVIOUR
//   load_use = ID_EX_mem_rd_en & ID_EX_reg_wr_en & (ID_EX_rd!=0) &
//              ((IF_ID_rs1_used & IF_ID_rs1==ID_EX_rd) | (IF_ID_rs2_used & IF_ID_rs2==ID_EX_rd)).
//   rd==x0 and unused source fields never cause a hazard.
//   Outputs are combinational from state and inputs. Priority: rst_n=0 > ex_busy > EX_br_taken
//   > load stall > normal.
//   Reset (rst_n=0, async): state=RUN, cnt=0, stall_cycles=0.
//     Output values while in reset: pc_write=IF_ID_write=ID_EX_write=0; flushes, ctrl_sel, stall=0.
//   FSM states: RUN, LD_STALL.
//   ex_busy=1 (any state):
//     - Outputs: pc_write=IF_ID_write=ID_EX_write=0, IF_ID_flush=ctrl_sel=0, stall=1.
//     - State and cnt hold. EX_br_taken is ignored this cycle.
//   RUN, EX_br_taken=1:
//     - Outputs: pc_write=1, IF_ID_flush=1, ctrl_sel=1, writes=1.
//     - Wins over a simultaneous load_use; no stall results. State stays RUN.
//   RUN, load_use=1:
//     - Outputs: pc_write=IF_ID_write=0, ctrl_sel=1, ID_EX_write=1, stall=1.
//     - If LOAD_LAT>1: next state LD_STALL with cnt<=LOAD_LAT-1. Else stay RUN.
//   LD_STALL:
//     - Outputs: same as the load_use outputs.
//     - Each cycle cnt<=cnt-1. On the cycle cnt==1, next state is RUN.
//     - Total bubbles inserted = LOAD_LAT exactly.
//   LD_STALL, EX_br_taken=1:
//     - Stall aborts: branch outputs apply, state<=RUN, cnt<=0.
//   RUN, no event: all writes=1, flush/ctrl_sel/stall=0.
//   stall_cycles increments by 1 on every clock edge where stall=1. Holds at 2**PERF_WIDTH-1
//   (no wrap).
//   Reset asserted mid-stall returns to RUN immediately. The first post-reset cycle behaves
//   as RUN.
// TESTING
//   1. LOAD_LAT=1; ld x5 in ID/EX, add uses rs1=x5
//      -> one cycle pc_write=0, ctrl_sel=1; then normal; stall_cycles=1.
//   2. LOAD_LAT=3; same load-use -> exactly 3 consecutive stall cycles; stall_cycles=3;
//      RUN on the 4th cycle.
//   3. ld x0, or rs2=x5 with rs2_used=0 -> no stall, all writes=1.
//   4. load_use and EX_br_taken in the same cycle
//      -> IF_ID_flush=1, ctrl_sel=1, pc_write=1, no stall follows.
//   5. LOAD_LAT=3; EX_br_taken in the 2nd LD_STALL cycle -> flush, RUN next cycle;
//      stall_cycles=1 (the abort cycle is not counted).
//   6. ex_busy for 4 cycles during LD_STALL -> all writes=0, cnt frozen, stall resumes after;
//      PERF_WIDTH=2 saturates at 3; rst_n pulse mid-stall -> RUN, counter 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// The slave side belongs to the hazard unit and the master side to the pipeline.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_WIDTH     = 32
);
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic                      IF_ID_rs1_used;
  logic                      IF_ID_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
  logic                      ID_EX_mem_rd_en;
  logic                      ID_EX_reg_wr_en;
  logic                      EX_br_taken;
  logic                      ex_busy;
  logic                      pc_write;
  logic                      IF_ID_write;
  logic                      ID_EX_write;
  logic                      IF_ID_flush;
  logic                      ctrl_sel;
  logic                      stall;
  logic [PERF_WIDTH-1:0]     stall_cycles;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_rs1_used, IF_ID_rs2_used,
           ID_EX_rd, ID_EX_mem_rd_en, ID_EX_reg_wr_en, EX_br_taken, ex_busy,
    input  pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ctrl_sel, stall, stall_cycles
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_rs1_used, IF_ID_rs2_used,
           ID_EX_rd, ID_EX_mem_rd_en, ID_EX_reg_wr_en, EX_br_taken, ex_busy,
    output pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ctrl_sel, stall, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall, branch flush and EX-busy freeze control for the 5-stage core,
// with a saturating stall-cycle performance counter.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LAT       = 1,
  parameter int CNT_WIDTH      = 3,
  parameter int PERF_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_LD_STALL = 1'b1;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD  = CNT_WIDTH'(LOAD_LAT - 1);
  localparam logic [PERF_WIDTH-1:0] PERF_ONE  = PERF_WIDTH'(1);
  localparam logic [PERF_WIDTH-1:0] PERF_MAX  = {PERF_WIDTH{1'b1}};

  logic [0:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [PERF_WIDTH-1:0] r_stall_cycles;

  logic [0:0]            w_next_state;
  logic [CNT_WIDTH-1:0]  w_next_cnt;
  logic                  w_load_use;
  logic                  w_pc_write;
  logic                  w_if_id_write;
  logic                  w_id_ex_write;
  logic                  w_if_id_flush;
  logic                  w_ctrl_sel;
  logic                  w_stall;

  // x0 is never a real producer, and unused source fields never match.
  assign w_load_use = hz.ID_EX_mem_rd_en & hz.ID_EX_reg_wr_en &
                      (hz.ID_EX_rd != {REG_ADDR_WIDTH{1'b0}}) &
                      ((hz.IF_ID_rs1_used & (hz.IF_ID_rs1 == hz.ID_EX_rd)) |
                       (hz.IF_ID_rs2_used & (hz.IF_ID_rs2 == hz.ID_EX_rd)));

  // Output decode and next-state; priority is reset, EX busy, branch, load stall.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_id_ex_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_ctrl_sel    = 1'b0;
    w_stall       = 1'b0;
    if (!rst_n) begin
      w_next_state = S_RUN;
      w_next_cnt   = CNT_ZERO;
    end else if (hz.ex_busy) begin
      w_stall = 1'b1;
    end else if (hz.EX_br_taken) begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_id_ex_write = 1'b1;
      w_if_id_flush = 1'b1;
      w_ctrl_sel    = 1'b1;
      w_next_state  = S_RUN;
      w_next_cnt    = CNT_ZERO;
    end else if ((r_state == S_LD_STALL) || w_load_use) begin
      w_id_ex_write = 1'b1;
      w_ctrl_sel    = 1'b1;
      w_stall       = 1'b1;
      case (r_state)
        S_RUN: begin
          if (LOAD_LAT > 1) begin
            w_next_state = S_LD_STALL;
            w_next_cnt   = CNT_LOAD;
          end else begin
            w_next_state = S_RUN;
            w_next_cnt   = CNT_ZERO;
          end
        end
        S_LD_STALL: begin
          w_next_cnt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_LD_STALL;
          end
        end
        default: begin
          w_next_state = S_RUN;
          w_next_cnt   = CNT_ZERO;
        end
      endcase
    end else begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_id_ex_write = 1'b1;
    end
  end

  // FSM state and stall countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= {PERF_WIDTH{1'b0}};
    end else if (w_stall && (r_stall_cycles != PERF_MAX)) begin
      r_stall_cycles <= r_stall_cycles + PERF_ONE;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign hz.pc_write     = w_pc_write;
  assign hz.IF_ID_write  = w_if_id_write;
  assign hz.ID_EX_write  = w_id_ex_write;
  assign hz.IF_ID_flush  = w_if_id_flush;
  assign hz.ctrl_sel     = w_ctrl_sel;
  assign hz.stall        = w_stall;
  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: three controllers (LOAD_LAT=1; LOAD_LAT=3; LOAD_LAT=3 with a 2-bit
// counter) share one stimulus stream and are checked against hand-computed vectors.
module tb_hazard_ctrl_unit;

  // {pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ctrl_sel, stall}
  localparam logic [5:0] O_RST  = 6'b000000;
  localparam logic [5:0] O_NORM = 6'b111000;
  localparam logic [5:0] O_LD   = 6'b001011;
  localparam logic [5:0] O_BR   = 6'b111110;
  localparam logic [5:0] O_BUSY = 6'b000001;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       rs1u, rs2u, mrd, rwr, br, busy;

  int n_chk;
  int n_pass;

  hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(32)) if_a ();
  hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(32)) if_b ();
  hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(2))  if_c ();

  hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .LOAD_LAT(1), .CNT_WIDTH(3), .PERF_WIDTH(32))
    u_dut_a (.clk(clk), .rst_n(rst_n), .hz(if_a));
  hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .LOAD_LAT(3), .CNT_WIDTH(3), .PERF_WIDTH(32))
    u_dut_b (.clk(clk), .rst_n(rst_n), .hz(if_b));
  hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .LOAD_LAT(3), .CNT_WIDTH(3), .PERF_WIDTH(2))
    u_dut_c (.clk(clk), .rst_n(rst_n), .hz(if_c));

  assign if_a.IF_ID_rs1 = rs1;  assign if_b.IF_ID_rs1 = rs1;  assign if_c.IF_ID_rs1 = rs1;
  assign if_a.IF_ID_rs2 = rs2;  assign if_b.IF_ID_rs2 = rs2;  assign if_c.IF_ID_rs2 = rs2;
  assign if_a.IF_ID_rs1_used = rs1u; assign if_b.IF_ID_rs1_used = rs1u; assign if_c.IF_ID_rs1_used = rs1u;
  assign if_a.IF_ID_rs2_used = rs2u; assign if_b.IF_ID_rs2_used = rs2u; assign if_c.IF_ID_rs2_used = rs2u;
  assign if_a.ID_EX_rd = rd;    assign if_b.ID_EX_rd = rd;    assign if_c.ID_EX_rd = rd;
  assign if_a.ID_EX_mem_rd_en = mrd; assign if_b.ID_EX_mem_rd_en = mrd; assign if_c.ID_EX_mem_rd_en = mrd;
  assign if_a.ID_EX_reg_wr_en = rwr; assign if_b.ID_EX_reg_wr_en = rwr; assign if_c.ID_EX_reg_wr_en = rwr;
  assign if_a.EX_br_taken = br; assign if_b.EX_br_taken = br; assign if_c.EX_br_taken = br;
  assign if_a.ex_busy = busy;   assign if_b.ex_busy = busy;   assign if_c.ex_busy = busy;

  logic [5:0] out_a, out_b, out_c;
  assign out_a = {if_a.pc_write, if_a.IF_ID_write, if_a.ID_EX_write, if_a.IF_ID_flush, if_a.ctrl_sel, if_a.stall};
  assign out_b = {if_b.pc_write, if_b.IF_ID_write, if_b.ID_EX_write, if_b.IF_ID_flush, if_b.ctrl_sel, if_b.stall};
  assign out_c = {if_c.pc_write, if_c.IF_ID_write, if_c.ID_EX_write, if_c.IF_ID_flush, if_c.ctrl_sel, if_c.stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rs1 = 5'd1; rs2 = 5'd2; rs1u = 1'b1; rs2u = 1'b1;
    rd = 5'd3; mrd = 1'b0; rwr = 1'b1; br = 1'b0; busy = 1'b0;
  endtask

  task automatic set_lu();
    rs1 = 5'd5; rs2 = 5'd7; rs1u = 1'b1; rs2u = 1'b1;
    rd = 5'd5; mrd = 1'b1; rwr = 1'b1; br = 1'b0; busy = 1'b0;
  endtask

  // Checks this cycle's outputs, then advances to the next falling edge.
  task automatic cyc(input string tag, input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ec);
    #1;
    check_val({tag, "_a"}, {26'd0, out_a}, {26'd0, ea});
    check_val({tag, "_b"}, {26'd0, out_b}, {26'd0, eb});
    check_val({tag, "_c"}, {26'd0, out_c}, {26'd0, ec});
    @(negedge clk);
  endtask

  task automatic cnt_chk(input string tag, input int ea, input int eb, input int ec);
    check_val({tag, "_cnt_a"}, if_a.stall_cycles, 32'(ea));
    check_val({tag, "_cnt_b"}, if_b.stall_cycles, 32'(eb));
    check_val({tag, "_cnt_c"}, {30'd0, if_c.stall_cycles}, 32'(ec));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    #1;
    cnt_chk("reset", 0, 0, 0);
    cyc("reset", O_RST, O_RST, O_RST);
    rst_n = 1'b1;

    set_idle(); cyc("idle", O_NORM, O_NORM, O_NORM);

    // load-use on rs1: one bubble for A, three for B/C
    set_lu();   cyc("lu", O_LD, O_LD, O_LD);
    set_idle(); #1; cnt_chk("lu1", 1, 1, 1); cyc("st2", O_NORM, O_LD, O_LD);
    set_idle(); cyc("st3", O_NORM, O_LD, O_LD);
    set_idle(); #1; cnt_chk("lu3", 1, 3, 3); cyc("run4", O_NORM, O_NORM, O_NORM);

    // no hazard cases
    set_idle(); rd = 5'd0; mrd = 1'b1; rs1 = 5'd0; cyc("ld_x0", O_NORM, O_NORM, O_NORM);
    set_lu(); rs1 = 5'd6; rs2 = 5'd5; rs2u = 1'b0; cyc("rs2_unused", O_NORM, O_NORM, O_NORM);
    set_lu(); rwr = 1'b0; cyc("no_wr", O_NORM, O_NORM, O_NORM);
    set_lu(); mrd = 1'b0; cyc("no_load", O_NORM, O_NORM, O_NORM);

    // hazard through rs2
    set_lu(); rs1 = 5'd6; rs2 = 5'd5; cyc("lu_rs2", O_LD, O_LD, O_LD);
    set_idle(); cyc("rs2_st2", O_NORM, O_LD, O_LD);
    set_idle(); cyc("rs2_st3", O_NORM, O_LD, O_LD);
    set_idle(); #1; cnt_chk("rs2", 2, 6, 3); cyc("rs2_run", O_NORM, O_NORM, O_NORM);

    // branch beats load-use
    set_lu(); br = 1'b1; cyc("lu_br", O_BR, O_BR, O_BR);
    set_idle(); #1; cnt_chk("lu_br", 2, 6, 3); cyc("lu_br_after", O_NORM, O_NORM, O_NORM);

    // branch aborts a stall in its second cycle
    set_lu();   cyc("abort_lu", O_LD, O_LD, O_LD);
    set_idle(); br = 1'b1; cyc("abort_br", O_BR, O_BR, O_BR);
    set_idle(); #1; cnt_chk("abort", 3, 7, 3); cyc("abort_run", O_NORM, O_NORM, O_NORM);

    // EX busy freezes a stall for 4 cycles
    set_lu(); cyc("busy_lu", O_LD, O_LD, O_LD);
    for (int i = 0; i < 4; i++) begin
      set_idle(); busy = 1'b1; cyc("busy", O_BUSY, O_BUSY, O_BUSY);
    end
    set_idle(); cyc("resume2", O_NORM, O_LD, O_LD);
    set_idle(); cyc("resume3", O_NORM, O_LD, O_LD);
    set_idle(); #1; cnt_chk("busy", 8, 14, 3); cyc("busy_run", O_NORM, O_NORM, O_NORM);

    // busy masks a branch
    set_idle(); br = 1'b1; busy = 1'b1; cyc("busy_br", O_BUSY, O_BUSY, O_BUSY);
    set_idle(); #1; cnt_chk("busy_br", 9, 15, 3); cyc("busy_br_after", O_NORM, O_NORM, O_NORM);

    // reset pulse mid-stall
    set_lu(); cyc("rst_lu", O_LD, O_LD, O_LD);
    set_idle(); rst_n = 1'b0; #1; cnt_chk("rst_mid", 0, 0, 0); cyc("rst_mid", O_RST, O_RST, O_RST);
    rst_n = 1'b1;
    set_idle(); cyc("post_rst", O_NORM, O_NORM, O_NORM);
    #1; cnt_chk("post_rst", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
